// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard and a registered pending-producer count.
// Optional write-to-read forwarding is enabled with REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              RsvWre,
    input  logic [ADDR_W-1:0] RsvReg,
    input  logic              Flush,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W:0]   PendCnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  pend_cnt_q;
    logic [CNT_W-1:0]  pend_cnt_d;

    logic wr_en;
    logic rsv_en;
    logic rsv_new;
    logic wr_retire;

    assign wr_en  = RegWre && (WriteReg != '0);
    assign rsv_en = RsvWre && (RsvReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteReg] = WriteData;
        end
    end

    // Reserve is applied last so it wins over both the write clear and flush.
    always_comb begin
        busy_d = Flush ? '0 : busy_q;
        if (wr_en) begin
            busy_d[WriteReg] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[RsvReg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rsv_new   = rsv_en && !busy_q[RsvReg];
        wr_retire = wr_en && busy_q[WriteReg] && !(rsv_en && (RsvReg == WriteReg));
        if (Flush) begin
            pend_cnt_d = CNT_W'(rsv_en);
        end else begin
            pend_cnt_d = pend_cnt_q + CNT_W'(rsv_new) - CNT_W'(wr_retire);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign PendCnt = pend_cnt_q;

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        Busy1     = 1'b0;
        Busy2     = 1'b0;
        if (Reset) begin
            ReadData1 = regs_q[rs];
            ReadData2 = regs_q[rt];
            Busy1     = busy_q[rs];
            Busy2     = busy_q[rt];
`ifdef REGFILE_SB_BYPASS_EN
            // Forwarded busy shows the post-edge state of the written register.
            if (wr_en && (WriteReg == rs)) begin
                ReadData1 = WriteData;
                Busy1     = rsv_en && (RsvReg == rs);
            end
            if (wr_en && (WriteReg == rt)) begin
                ReadData2 = WriteData;
                Busy2     = rsv_en && (RsvReg == rt);
            end
`endif
            if (rs == '0) begin
                ReadData1 = '0;
                Busy1     = 1'b0;
            end
            if (rt == '0) begin
                ReadData2 = '0;
                Busy2     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          RegWre;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic          RsvWre;
    logic [AW-1:0] RsvReg;
    logic          Flush;
    logic          Busy1;
    logic          Busy2;
    logic [AW:0]   PendCnt;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .Reset(Reset), .RegWre(RegWre), .WriteReg(WriteReg),
        .WriteData(WriteData), .rs(rs), .rt(rt), .ReadData1(ReadData1),
        .ReadData2(ReadData2), .RsvWre(RsvWre), .RsvReg(RsvReg), .Flush(Flush),
        .Busy1(Busy1), .Busy2(Busy2), .PendCnt(PendCnt)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] m_reg [DEPTH];
    bit            m_busy [DEPTH];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_pend();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (!Reset || a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
        if (RegWre && WriteReg == a) return WriteData;
`endif
        return m_reg[a];
    endfunction

    function automatic logic m_bsy(input logic [AW-1:0] a);
        if (!Reset || a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (RegWre && WriteReg == a) return RsvWre && RsvReg == a;
`endif
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Rules in priority order: write clears, flush clears all, reserve sets last.
    task automatic model_edge();
        if (!Reset) return;
        if (RegWre && WriteReg != 0) begin
            m_reg[WriteReg]  = WriteData;
            m_busy[WriteReg] = 1'b0;
        end
        if (Flush) for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        if (RsvWre && RsvReg != 0) m_busy[RsvReg] = 1'b1;
    endtask

    task automatic check_all();
        chk("rd1", ReadData1, m_rd(rs));
        chk("rd2", ReadData2, m_rd(rt));
        chk("busy1", 32'(Busy1), 32'(m_bsy(rs)));
        chk("busy2", 32'(Busy2), 32'(m_bsy(rt)));
        chk("pend", 32'(PendCnt), Reset ? 32'(m_pend()) : 32'd0);
    endtask

    task automatic idle();
        RegWre = 0; WriteReg = '0; WriteData = '0;
        RsvWre = 0; RsvReg = '0; Flush = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check_all();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b0;
        model_clear();
        // Traffic offered during reset must be discarded.
        RegWre = 1; WriteReg = 5'd9; WriteData = 32'hBAD0BAD0;
        RsvWre = 1; RsvReg = 5'd9; rs = 5'd9; rt = 5'd9;
        tick();
        tick();
        idle();
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        rs = '0; rt = '0;
        model_clear();
        do_reset();

        // All registers read zero after reset, then a simple write/readback.
        for (int i = 0; i < DEPTH; i += 2) begin
            rs = 5'(i); rt = 5'(i + 1);
            tick();
        end
        RegWre = 1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
        tick();
        idle(); rs = 5'd5;
        #1 chk("r5_dead", ReadData1, 32'hDEADBEEF);
        tick();

        // Register zero ignores writes and reserves.
        RegWre = 1; WriteReg = 5'd0; WriteData = 32'h1234;
        RsvWre = 1; RsvReg = 5'd0;
        tick();
        idle(); rs = 5'd0;
        #1;
        chk("r0_data", ReadData1, 32'h0);
        chk("r0_busy", 32'(Busy1), 32'd0);
        chk("r0_pend", 32'(PendCnt), 32'd0);
        tick();

        // Reserve three, then retire one.
        RsvWre = 1; RsvReg = 5'd3; tick();
        #1 chk("pend_1", 32'(PendCnt), 32'd1);
        RsvReg = 5'd7; tick();
        #1 chk("pend_2", 32'(PendCnt), 32'd2);
        RsvReg = 5'd9; tick();
        #1 chk("pend_3", 32'(PendCnt), 32'd3);
        idle(); RegWre = 1; WriteReg = 5'd7; WriteData = 32'h7777;
        tick();
        idle(); rs = 5'd7;
        #1;
        chk("pend_w7", 32'(PendCnt), 32'd2);
        chk("busy_r7", 32'(Busy1), 32'd0);
        tick();

        // Same-cycle write and reserve; then flush against a reserve.
        do_reset();
        RsvWre = 1; RsvReg = 5'd1; tick();
        RsvReg = 5'd2; tick();
        RsvReg = 5'd4; RegWre = 1; WriteReg = 5'd4; WriteData = 32'hA5;
        tick();
        idle(); rs = 5'd4;
        #1;
        chk("r4_data", ReadData1, 32'hA5);
        chk("r4_busy", 32'(Busy1), 32'd1);
        chk("pend_wr_rsv", 32'(PendCnt), 32'd3);
        Flush = 1; RsvWre = 1; RsvReg = 5'd8;
        tick();
        idle(); rs = 5'd4; rt = 5'd8;
        #1;
        chk("pend_flush", 32'(PendCnt), 32'd1);
        chk("flush_r4", 32'(Busy1), 32'd0);
        chk("flush_r8", 32'(Busy2), 32'd1);
        chk("flush_data", ReadData1, 32'hA5);
        tick();

        // Same-cycle read of a register being written.
        RegWre = 1; WriteReg = 5'd6; WriteData = 32'h55AA; rs = 5'd6;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("r6_pre", ReadData1, 32'h55AA);
`else
        chk("r6_pre", ReadData1, 32'h0);
`endif
        tick();
        idle(); rs = 5'd6;
        #1 chk("r6_post", ReadData1, 32'h55AA);
        tick();

        // Randomized traffic; narrow address range half the time to force collisions.
        for (int n = 0; n < 600; n++) begin
            logic narrow;
            narrow    = 1'($urandom_range(0, 1));
            RegWre    = ($urandom_range(0, 99) < 45);
            WriteReg  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            WriteData = $urandom;
            RsvWre    = ($urandom_range(0, 99) < 45);
            RsvReg    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            Flush     = ($urandom_range(0, 99) < 5);
            rs        = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rt        = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            tick();
        end

        // Asynchronous reset in mid-cycle.
        do_reset();
        RegWre = 1; WriteReg = 5'd2; WriteData = 32'h77; tick();
        idle(); RsvWre = 1;
        RsvReg = 5'd1; tick();
        RsvReg = 5'd3; tick();
        RsvReg = 5'd4; tick();
        RsvReg = 5'd5; tick();
        idle(); rs = 5'd2; rt = 5'd3;
        #1;
        chk("pre_rst_pend", 32'(PendCnt), 32'd4);
        chk("pre_rst_r2", ReadData1, 32'h77);
        @(posedge CLK);
        #2 Reset = 1'b0;
        model_clear();
        #1;
        chk("arst_rd1", ReadData1, 32'h0);
        chk("arst_pend", 32'(PendCnt), 32'd0);
        chk("arst_busy2", 32'(Busy2), 32'd0);
        rs = 5'd1; #1;
        chk("arst_busy1", 32'(Busy1), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        rs = 5'd2; rt = 5'd4;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port RegWre  input  1  write enable.
REQ-006 The block SHALL have port WriteReg  input  ADDR_W  write address.
REQ-007 The block SHALL have port WriteData  input  DATA_W  write data.
REQ-008 The block SHALL have ports rs and rt, each  input  ADDR_W  read addresses for ports 1 and 2.
REQ-009 The block SHALL have ports ReadData1 and ReadData2, each  output  DATA_W  combinational read data.
REQ-010 The block SHALL have port RsvWre  input  1  reserve request marking a register busy (pending producer).
REQ-011 The block SHALL have port RsvReg  input  ADDR_W  register address to reserve.
REQ-012 The block SHALL have port Flush  input  1  clear all busy bits.
REQ-013 The block SHALL have ports Busy1 and Busy2, each  output  1  busy bit of rs and rt respectively.
REQ-014 The block SHALL have port PendCnt  output  ADDR_W+1  registered count of busy registers.

Function
REQ-015 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never become busy; reserve of address 0 is a no-op.
REQ-016 When RegWre=1 and WriteReg!=0, the register SHALL take WriteData on the rising CLK edge and its busy bit SHALL clear on the same edge.
REQ-017 When RsvWre=1 and RsvReg!=0, the busy bit of RsvReg SHALL set on the rising CLK edge.
REQ-018 When a write and a reserve target the same register in one cycle, the data SHALL be written and the busy bit SHALL end set, because reserve wins.
REQ-019 Flush=1 SHALL clear every busy bit on the edge; a reserve in the same cycle SHALL still set its bit, because reserve has priority over flush.
REQ-020 Register data SHALL NOT be affected by Flush.
REQ-021 Busy1 and Busy2 SHALL be combinational reads of the busy vector (pre-edge state); address 0 SHALL give 0.
REQ-022 PendCnt SHALL equal the population count of the busy vector after each edge and SHALL be maintained incrementally: +1 for a newly set bit, -1 for a newly cleared bit, with net 0 when both occur on different registers and for a redundant set or clear; it SHALL never wrap.
REQ-023 Read latency SHALL be zero cycles: ReadData1 and ReadData2 follow rs and rt combinationally.

Reset
REQ-024 When Reset=0, all registers SHALL clear to 0, all busy bits SHALL clear, and PendCnt SHALL be 0, asynchronously and independently of CLK.
REQ-025 Writes, reserves and flushes presented while Reset=0 SHALL be discarded; the first update SHALL occur on the first rising edge after Reset returns to 1.
REQ-026 During Reset, ReadData1, ReadData2, Busy1 and Busy2 SHALL read 0.

Configuration
REQ-027 With macro REGFILE_SB_BYPASS_EN defined, when RegWre=1, WriteReg!=0 and WriteReg equals rs (or rt), ReadData1 (or ReadData2) SHALL return WriteData in the same cycle, and Busy1 (or Busy2) SHALL read 0 unless RsvWre targets that same register.
REQ-028 Without REGFILE_SB_BYPASS_EN, read ports SHALL return the stored value only, so the new value appears the cycle after the write edge, and busy outputs SHALL reflect the stored busy bits only.

Verification
REQ-029 Scenario: Reset low, then write 0xDEADBEEF to r5 and read rs=5 next cycle -> ReadData1=0xDEADBEEF, and all registers read 0 before the write.
REQ-030 Scenario: write 0x1234 to r0, then read rs=0, and reserve r0 -> ReadData1=0, Busy1=0 and PendCnt=0.
REQ-031 Scenario: reserve r3, r7 and r9 over three cycles -> PendCnt=1, 2, 3; write r7 -> PendCnt=2 and Busy for rs=7 reads 0.
REQ-032 Scenario: in one cycle reserve r4 and write r4=0xA5 -> r4=0xA5, Busy=1, PendCnt+1; with PendCnt=3, Flush plus reserve r8 -> PendCnt=1, only r8 busy.
REQ-033 Scenario with REGFILE_SB_BYPASS_EN: rs=6, and write r6=0x55AA in the same cycle -> ReadData1=0x55AA before the edge; without the macro -> old value before the edge, 0x55AA after it.
REQ-034 Scenario: assert Reset low mid-cycle with r2=0x77 and PendCnt=4 -> immediately ReadData=0, PendCnt=0 and all Busy=0, without waiting for a CLK edge.
